// File: rtl/pbox_pipe.sv
// pbox_pipe: pipelined PRESENT-style bit permutation with valid/ready flow.
//
// The permutation is P(i) = (i*WIDTH/4) mod (WIDTH-1), with P(WIDTH-1) =
// WIDTH-1. Forward mode moves input bit i to output bit P(i). Inverse mode
// takes output bit i from input bit P(i). The direction is chosen per word
// by in_inv and travels with that word. Both networks are plain wiring. The
// only logic ahead of stage 1 is the direction mux, and nothing follows the
// last register.
//
// Parameters
//   WIDTH   state width, power of two in 16..128 (16 = legacy mapping)
//   STAGES  register stages, 1..4; equals the latency in cycles
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   input word present
//   in_ready   block can accept a word this cycle (0 while rst is high)
//   in_data    word to permute
//   in_inv     0 = forward P, 1 = inverse P^-1
//   out_valid  out_data holds a result
//   out_ready  downstream accepts the result
//   out_data   permuted word
//   out_inv    in_inv carried alongside the word
//   pbox_count saturating count of output transfers (only when
//              PBOX_PIPE_COUNT_EN is defined)
//
// Optional feature macro: PBOX_PIPE_COUNT_EN

module pbox_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_inv
`ifdef PBOX_PIPE_COUNT_EN
    ,
    output logic [15:0]      pbox_count
`endif
);

    // Parameter legality. WIDTH/4 and WIDTH-1 are coprime for every power of
    // two in range, so P is always a bijection.
    if (WIDTH < 16 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pbox_pipe: WIDTH must be a power of two in 16..128");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pbox_pipe: STAGES must be in 1..4");
    end

    logic [WIDTH-1:0] perm_fwd;
    logic [WIDTH-1:0] perm_inv;
    logic [WIDTH-1:0] perm_sel;

    for (genvar i = 0; i < WIDTH; i++) begin : g_perm
        localparam int P = (i == WIDTH - 1) ? WIDTH - 1 : (i * (WIDTH / 4)) % (WIDTH - 1);
        assign perm_fwd[P] = in_data[i];
        assign perm_inv[i] = in_data[P];
    end

    assign perm_sel = in_inv ? perm_inv : perm_fwd;

    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_inv;
    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [STAGES-1:0] stg_load;

    // Per-stage source: stage 0 is fed by the mux, the others by the stage
    // in front of them.
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_inv;
    logic [WIDTH-1:0]  src_data [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_valid[k] = in_valid;
            assign src_inv[k]   = in_inv;
            assign src_data[k]  = perm_sel;
        end else begin : g_body
            assign src_valid[k] = stg_valid[k-1];
            assign src_inv[k]   = stg_inv[k-1];
            assign src_data[k]  = stg_data[k-1];
        end
    end

    // A stage may load when it is empty or when its successor loads this
    // cycle. The chain runs from out_ready back to stage 0. The running term
    // is a local variable so that the vector never depends on itself.
    always_comb begin
        logic chain;
        chain    = out_ready;
        stg_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain       = !stg_valid[k] || chain;
            stg_load[k] = chain;
        end
    end

    assign in_ready = stg_load[0] && !rst;

    // Data and inv only change when a real word arrives. A bubble moving in
    // clears valid but leaves the last payload in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= '0;
            stg_inv   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stg_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (stg_load[k]) begin
                    stg_valid[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        stg_data[k] <= src_data[k];
                        stg_inv[k]  <= src_inv[k];
                    end
                end
            end
        end
    end

    assign out_valid = stg_valid[STAGES-1];
    assign out_data  = stg_data[STAGES-1];
    assign out_inv   = stg_inv[STAGES-1];

`ifdef PBOX_PIPE_COUNT_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_valid && out_ready && count_q != 16'hFFFF) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign pbox_count = count_q;
`endif

endmodule

// File: tb/tb_pbox_pipe.sv
module tb_pbox_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // u16: WIDTH=16 STAGES=1
    logic        a_iv, a_ir, a_ii, a_ov, a_or, a_oi;
    logic [15:0] a_id, a_od;
    // u64: WIDTH=64 STAGES=3
    logic        b_iv, b_ir, b_ii, b_ov, b_or, b_oi;
    logic [63:0] b_id, b_od;
    // u2: WIDTH=64 STAGES=2
    logic        c_iv, c_ir, c_ii, c_ov, c_or, c_oi;
    logic [63:0] c_id, c_od;
`ifdef PBOX_PIPE_COUNT_EN
    logic [15:0] a_cnt, b_cnt, c_cnt;
`endif

    pbox_pipe #(.WIDTH(16), .STAGES(1)) u16 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .in_inv(a_ii), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .out_inv(a_oi)
`ifdef PBOX_PIPE_COUNT_EN
        , .pbox_count(a_cnt)
`endif
    );

    pbox_pipe #(.WIDTH(64), .STAGES(3)) u64 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .in_inv(b_ii), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .out_inv(b_oi)
`ifdef PBOX_PIPE_COUNT_EN
        , .pbox_count(b_cnt)
`endif
    );

    pbox_pipe #(.WIDTH(64), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .in_inv(c_ii), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .out_inv(c_oi)
`ifdef PBOX_PIPE_COUNT_EN
        , .pbox_count(c_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference permutation straight from the bit-mapping rule.
    function automatic logic [127:0] pbox_ref(input int w, input logic [127:0] x, input logic inv);
        logic [127:0] r;
        int p;
        r = '0;
        for (int i = 0; i < w; i++) begin
            p = (i == w - 1) ? i : (i * (w / 4)) % (w - 1);
            if (!inv) r[p] = x[i];
            else      r[i] = x[p];
        end
        return r;
    endfunction

    // Scoreboard per unit: expected {inv, data} in acceptance order.
    logic [128:0] q [3][$];
    int           n_out [3];
    logic         held [3];
    logic [128:0] held_val [3];
    logic [15:0]  cnt_model [3];

    task automatic scan(input int u, input int w, input logic iv, input logic ir,
                        input logic [127:0] id, input logic ii, input logic ov,
                        input logic orr, input logic [127:0] od, input logic oi);
        logic [128:0] exp;
        if (held[u]) begin
            check($sformatf("hold_valid_u%0d", u), 128'(ov), 128'(1));
            check($sformatf("hold_data_u%0d", u), {oi, od[126:0]} , {held_val[u][128], held_val[u][126:0]});
        end
        if (ov) begin
            if (q[u].size() == 0) begin
                check($sformatf("spurious_valid_u%0d", u), 128'(ov), 128'(0));
            end else if (orr) begin
                exp = q[u].pop_front();
                check($sformatf("out_data_u%0d", u), od, exp[127:0]);
                check($sformatf("out_inv_u%0d", u), 128'(oi), 128'(exp[128]));
                n_out[u]++;
                if (cnt_model[u] != 16'hFFFF) cnt_model[u]++;
            end
        end
        held[u]     = ov && !orr;
        held_val[u] = {oi, od};
        if (iv && ir) q[u].push_back({ii, pbox_ref(w, id, ii)});
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int u = 0; u < 3; u++) begin
                q[u].delete();
                held[u]      = 1'b0;
                cnt_model[u] = '0;
            end
            check("rst_out_valid", 128'({a_ov, b_ov, c_ov}), 128'(0));
            check("rst_in_ready", 128'({a_ir, b_ir, c_ir}), 128'(0));
        end else begin
`ifdef PBOX_PIPE_COUNT_EN
            check("count_u0", 128'(a_cnt), 128'(cnt_model[0]));
            check("count_u1", 128'(b_cnt), 128'(cnt_model[1]));
            check("count_u2", 128'(c_cnt), 128'(cnt_model[2]));
`endif
            scan(0, 16, a_iv, a_ir, 128'(a_id), a_ii, a_ov, a_or, 128'(a_od), a_oi);
            scan(1, 64, b_iv, b_ir, 128'(b_id), b_ii, b_ov, b_or, 128'(b_od), b_oi);
            scan(2, 64, c_iv, c_ir, 128'(c_id), c_ii, c_ov, c_or, 128'(c_od), c_oi);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One word through u16 with hand-computed expectation.
    task automatic send_a(input logic [15:0] d, input logic inv, input logic [15:0] exp);
        a_id = d;
        a_ii = inv;
        a_iv = 1'b1;
        tick();
        a_iv = 1'b0;
        check("a_lit_valid", 128'(a_ov), 128'(1));
        check("a_lit_data", 128'(a_od), 128'(exp));
        check("a_lit_inv", 128'(a_oi), 128'(inv));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] lit_in  [5];
        logic [15:0] lit_out [5];
        logic [15:0] w16;
        logic [63:0] cw [3];
        int lat, stalls, n0, acc;
        logic took;

        for (int u = 0; u < 3; u++) begin
            n_out[u] = 0; held[u] = 1'b0; cnt_model[u] = '0;
        end
        rst  = 1'b0;
        a_iv = 0; a_ii = 0; a_id = '0; a_or = 1;
        b_iv = 0; b_ii = 0; b_id = '0; b_or = 1;
        c_iv = 0; c_ii = 0; c_id = '0; c_or = 1;
        #2 rst = 1'b1;
        repeat (3) tick();
        check("rst_ready_u0", 128'(a_ir), 128'(0));
        check("rst_ready_u1", 128'(b_ir), 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_valid", 128'(b_ov), 128'(0));
        check("post_rst_data", 128'(b_od), 128'(0));
        check("post_rst_inv", 128'(b_oi), 128'(0));
        check("post_rst_ready_u1", 128'(b_ir), 128'(1));
        check("post_rst_ready_u0", 128'(a_ir), 128'(1));
        tick();

        // Legacy 16-bit mapping, literal vectors.
        lit_in[0] = 16'h0002; lit_out[0] = 16'h0010;
        lit_in[1] = 16'h0008; lit_out[1] = 16'h1000;
        lit_in[2] = 16'h4000; lit_out[2] = 16'h0800;
        lit_in[3] = 16'h8000; lit_out[3] = 16'h8000;
        lit_in[4] = 16'h0001; lit_out[4] = 16'h0001;
        for (int i = 0; i < 5; i++) send_a(lit_in[i], 1'b0, lit_out[i]);
        send_a(16'h0010, 1'b1, 16'h0002);
        for (int i = 0; i < 4; i++) begin
            w16 = 16'($urandom);
            send_a(w16, 1'b0, 16'(pbox_ref(16, 128'(w16), 1'b0)));
            send_a(16'(pbox_ref(16, 128'(w16), 1'b0)), 1'b1, w16);
        end

        // Latency on the 3-stage unit.
        b_id = 64'h2; b_ii = 1'b0; b_iv = 1'b1;
        tick();
        b_iv = 1'b0;
        lat = 1;
        while (!b_ov && lat < 10) begin tick(); lat++; end
        check("b_latency", 128'(lat), 128'(3));
        check("b_lit_data", 128'(b_od), 128'(64'h10000));
        tick();
        b_id = 64'h8000_0000_0000_0000; b_iv = 1'b1;
        tick();
        b_iv = 1'b0;
        repeat (2) tick();
        check("b_msb_valid", 128'(b_ov), 128'(1));
        check("b_msb_data", 128'(b_od), 128'(64'h8000_0000_0000_0000));
        tick();

        // 100 back-to-back words, alternating direction.
        n0 = n_out[1];
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            b_id = {$urandom, $urandom};
            b_ii = 1'(i & 1);
            b_iv = 1'b1;
            #1;
            if (!b_ir) stalls++;
            @(posedge clk);
            #1;
        end
        b_iv = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        #1;
        check("b_stream_stalls", 128'(stalls), 128'(0));
        check("b_stream_count", 128'(n_out[1] - n0), 128'(100));
        tick();

        // Backpressure on the 2-stage unit.
        cw[0] = 64'h0123_4567_89AB_CDEF;
        cw[1] = 64'hFEDC_BA98_7654_3210;
        cw[2] = 64'hA5A5_0F0F_3C3C_9696;
        n0 = n_out[2];
        c_or = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            if (acc < 3) begin c_id = cw[acc]; c_ii = 1'(acc & 1); c_iv = 1'b1; end
            else c_iv = 1'b0;
            #1;
            took = c_ir && c_iv;
            @(posedge clk);
            #1;
            if (took) acc++;
        end
        check("c_bp_accepted", 128'(acc), 128'(2));
        check("c_bp_ready", 128'(c_ir), 128'(0));
        check("c_bp_head", 128'(c_od), pbox_ref(64, 128'(cw[0]), 1'b0));
        c_or = 1'b1;
        for (int cyc = 0; cyc < 10 && acc < 3; cyc++) begin
            #1;
            took = c_ir && c_iv;
            @(posedge clk);
            #1;
            if (took) acc++;
        end
        c_iv = 1'b0;
        repeat (4) tick();
        check("c_bp_all_in", 128'(acc), 128'(3));
        check("c_bp_all_out", 128'(n_out[2] - n0), 128'(3));

        // Reset with words in flight on the 3-stage unit.
        b_or = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_id = 64'h1111_0000_0000_0001 << i; b_ii = 1'b0; b_iv = 1'b1;
            tick();
        end
        b_iv = 1'b0;
        check("b_full_valid", 128'(b_ov), 128'(1));
        #3 rst = 1'b1;
        #1;
        check("b_async_rst_valid", 128'(b_ov), 128'(0));
        check("b_async_rst_data", 128'(b_od), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        b_or = 1'b1;
        #1;
        check("b_rst_ready", 128'(b_ir), 128'(1));
        n0 = n_out[1];
        repeat (6) tick();
        check("b_no_stale", 128'(n_out[1] - n0), 128'(0));

`ifdef PBOX_PIPE_COUNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            a_or = 1'b0;
            a_id = 16'(i + 1); a_ii = 1'b0; a_iv = 1'b1;
            tick();
            a_iv = 1'b0;
            tick();
            a_or = 1'b1;
            tick();
        end
        tick();
        check("a_count_five", 128'(a_cnt), 128'(5));
        force u16.count_q = 16'hFFFE;
        #1;
        release u16.count_q;
        cnt_model[0] = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            a_id = 16'(i + 7); a_iv = 1'b1;
            tick();
            a_iv = 1'b0;
            tick();
        end
        tick();
        check("a_count_sat", 128'(a_cnt), 128'(16'hFFFF));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
